// File: rtl/ram_req_ctrl.sv
// Queued read/write front-end for a RAM with registered read data; optional RAM_CTRL_ADDR_CHECK_EN range check.
// Latency: accepted command issues 1 cycle later; read accept -> rsp_valid 3 cycles in an idle system.
// Backpressure: req_ready low while the command FIFO is full; a read head stalls at 2 outstanding responses.
module ram_req_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int MEM_DEPTH = 8,
    parameter int CMD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wr_drop,
    output logic              ram_wr_enb,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_rd_enb,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam logic [PTR_W:0] CMD_FULL = (PTR_W+1)'(CMD_DEPTH);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    cmd_t             cmd_mem [CMD_DEPTH];
    logic [PTR_W-1:0] cmd_wr_ptr;
    logic [PTR_W-1:0] cmd_rd_ptr;
    logic [PTR_W:0]   cmd_cnt;
    cmd_t             cmd_head;
    logic             cmd_push;
    logic             cmd_pop;

    rsp_t       rsp_mem [2];
    logic       rsp_wr_ptr;
    logic       rsp_rd_ptr;
    logic [1:0] rsp_cnt;
    rsp_t       rsp_head;
    logic       rsp_push;
    logic       rsp_pop;

    logic rd_pend;
    logic rd_pend_err;
    logic rd_take;
    logic addr_ok;
    logic credit_ok;

    assign cmd_head  = cmd_mem[cmd_rd_ptr];
    assign req_ready = (cmd_cnt != CMD_FULL) && !rst;
    assign cmd_push  = req_valid && req_ready;

`ifdef RAM_CTRL_ADDR_CHECK_EN
    assign addr_ok = {1'b0, cmd_head.addr} < (ADDR_W+1)'(MEM_DEPTH);
`else
    assign addr_ok = 1'b1;
`endif

    // A read counts against the credit from issue until its response is popped.
    assign credit_ok = ({1'b0, rd_pend} + rsp_cnt) < 2'd2;

    always_comb begin
        cmd_pop     = 1'b0;
        rd_take     = 1'b0;
        wr_drop     = 1'b0;
        ram_wr_enb  = 1'b0;
        ram_wr_addr = '0;
        ram_data_in = '0;
        ram_rd_enb  = 1'b0;
        ram_rd_addr = '0;
        if (!rst && cmd_cnt != '0) begin
            if (cmd_head.wr) begin
                cmd_pop = 1'b1;
                if (addr_ok) begin
                    ram_wr_enb  = 1'b1;
                    ram_wr_addr = cmd_head.addr;
                    ram_data_in = cmd_head.wdata;
                end else begin
                    wr_drop = 1'b1;
                end
            end else if (credit_ok) begin
                cmd_pop = 1'b1;
                rd_take = 1'b1;
                if (addr_ok) begin
                    ram_rd_enb  = 1'b1;
                    ram_rd_addr = cmd_head.addr;
                end
            end
        end
    end

    assign rsp_head  = rsp_mem[rsp_rd_ptr];
    assign rsp_valid = rsp_cnt != 2'd0;
    assign rsp_rdata = rsp_valid ? rsp_head.rdata : '0;
    assign rsp_err   = rsp_valid && rsp_head.err;
    assign rsp_push  = rd_pend;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign busy      = (cmd_cnt != '0) || rd_pend || rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wr_ptr  <= '0;
            cmd_rd_ptr  <= '0;
            cmd_cnt     <= '0;
            rd_pend     <= 1'b0;
            rd_pend_err <= 1'b0;
            rsp_wr_ptr  <= 1'b0;
            rsp_rd_ptr  <= 1'b0;
            rsp_cnt     <= 2'd0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + PTR_W'(1);
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + PTR_W'(1);
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt <= cmd_cnt + (PTR_W+1)'(1);
                2'b01:   cmd_cnt <= cmd_cnt - (PTR_W+1)'(1);
                default: cmd_cnt <= cmd_cnt;
            endcase
            rd_pend     <= rd_take;
            rd_pend_err <= rd_take && !addr_ok;
            if (rsp_push) rsp_wr_ptr <= ~rsp_wr_ptr;
            if (rsp_pop)  rsp_rd_ptr <= ~rsp_rd_ptr;
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt <= rsp_cnt + 2'd1;
                2'b01:   rsp_cnt <= rsp_cnt - 2'd1;
                default: rsp_cnt <= rsp_cnt;
            endcase
        end
    end

    // Storage only; occupancy is governed by the pointers above.
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr] <= '{wr: req_wr, addr: req_addr, wdata: req_wdata};
        if (rsp_push) rsp_mem[rsp_wr_ptr] <= '{err: rd_pend_err, rdata: rd_pend_err ? '0 : ram_data_out};
    end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl: RAM model, transaction-level scoreboard, directed cases and random traffic.
module tb_ram_req_ctrl;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 4;
    localparam int MEM_DEPTH = 8;
    localparam int CMD_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              wr_drop;
    logic              ram_wr_enb;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_rd_enb;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_data_out;
    logic              busy;

    always #5 clk = ~clk;

    ram_req_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .CMD_DEPTH(CMD_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wr_drop(wr_drop),
        .ram_wr_enb(ram_wr_enb), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
        .ram_rd_enb(ram_rd_enb), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out),
        .busy(busy)
    );

    function automatic logic [DATA_W-1:0] seed(input int i);
        return (32'(i) * 32'h01010101) ^ 32'h5A00C300;
    endfunction

    function automatic bit addr_bad(input logic [ADDR_W-1:0] a);
`ifdef RAM_CTRL_ADDR_CHECK_EN
        return 32'(a) >= MEM_DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    // RAM with registered read data
    logic [DATA_W-1:0] ram [16];
    logic              ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= seed(i);
        end else if (ram_wr_enb) begin
            ram[ram_wr_addr] <= ram_data_in;
        end
        if (ram_rd_enb) ram_data_out <= ram[ram_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Transaction model: commands execute in acceptance order against ref_mem.
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_rsp_t;

    logic [DATA_W-1:0]        ref_mem [16];
    exp_rsp_t                 expq [$];
    logic [ADDR_W+DATA_W-1:0] wq [$];
    logic [ADDR_W-1:0]        rdq [$];
    int                       rd_issue_cnt = 0;
    int                       wr_issue_cnt = 0;
    int                       drop_cnt     = 0;
    int                       pop_cnt      = 0;
    logic [ADDR_W-1:0]        last_rd_addr = '0;
    logic                     prev_rst     = 1'b1;
    logic                     prev_hold    = 1'b0;
    exp_rsp_t                 prev_rsp;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_ram_ports", {ram_wr_enb, ram_wr_addr, ram_data_in, ram_rd_enb, ram_rd_addr}, 0);
            expq.delete();
            wq.delete();
            rdq.delete();
            for (int i = 0; i < 16; i++) ref_mem[i] = ram[i];
            prev_hold = 1'b0;
        end else begin
            if (prev_rst) begin
                chk("post_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
                chk("post_rst_busy_drop", {busy, wr_drop}, 0);
                chk("post_rst_req_ready", req_ready, 1);
                chk("post_rst_enables", {ram_wr_enb, ram_rd_enb}, 0);
            end
            chk("busy", busy, (wq.size() + expq.size()) != 0);
            if (!ram_wr_enb) chk("wr_port_idle", {ram_wr_addr, ram_data_in}, 0);
            if (!ram_rd_enb) chk("rd_port_idle", ram_rd_addr, 0);
`ifndef RAM_CTRL_ADDR_CHECK_EN
            chk("tied_low", {wr_drop, rsp_err}, 0);
`endif
            if (ram_wr_enb) begin
                wr_issue_cnt++;
                if (wq.size() == 0) chk("wr_unexpected", ram_wr_enb, 0);
                else chk("wr_port", {ram_wr_addr, ram_data_in}, wq.pop_front());
            end
            if (wr_drop) begin
                drop_cnt++;
                chk("drop_with_wr", ram_wr_enb, 0);
                if (wq.size() == 0) chk("drop_unexpected", wr_drop, 0);
                else chk("drop_addr_bad", addr_bad(wq.pop_front()[ADDR_W+DATA_W-1:DATA_W]), 1);
            end
            if (ram_rd_enb) begin
                rd_issue_cnt++;
                last_rd_addr = ram_rd_addr;
                if (rdq.size() == 0) chk("rd_unexpected", ram_rd_enb, 0);
                else chk("rd_port", ram_rd_addr, rdq.pop_front());
            end
            if (prev_hold) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_stable", {rsp_err, rsp_rdata}, prev_rsp);
            end
            if (rsp_valid) begin
                if (expq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else chk("rsp_data", {rsp_err, rsp_rdata}, expq[0]);
                if (rsp_ready && expq.size() != 0) begin
                    void'(expq.pop_front());
                    pop_cnt++;
                end
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_rsp  = {rsp_err, rsp_rdata};
            if (req_valid && req_ready) begin
                if (req_wr) begin
                    wq.push_back({req_addr, req_wdata});
                    if (!addr_bad(req_addr)) ref_mem[req_addr] = req_wdata;
                end else if (addr_bad(req_addr)) begin
                    expq.push_back({1'b1, {DATA_W{1'b0}}});
                end else begin
                    rdq.push_back(req_addr);
                    expq.push_back({1'b0, ref_mem[req_addr]});
                end
            end
        end
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                        output int acc_cyc);
        logic acc;
        int   t;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        acc       = 1'b0;
        t         = 0;
        acc_cyc   = -1;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc     = req_ready;
            acc_cyc = cyc;
            tick();
            t++;
        end
        req_valid = 1'b0;
        if (!acc) chk("send_accept", acc, 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 300) begin
            tick();
            t++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_rsp(output logic [DATA_W-1:0] d, output logic e, output int c);
        bit got;
        got = 1'b0;
        d   = '0;
        e   = 1'b0;
        c   = -1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                d   = rsp_rdata;
                e   = rsp_err;
                c   = cyc;
            end
        end
        tick();
        if (!got) chk("rsp_timeout", got, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int               c0, c1, c2;
        int               base_rd, base_pop, base_wr, base_drop;
        logic [DATA_W-1:0] d;
        logic             e;

        rst       = 1'b1;
        ram_init  = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) tick();
        ram_init = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Write then read the same address in consecutive cycles.
        wait_idle();
        send(1'b1, 4'd3, 32'hDEADBEEF, c0);
        send(1'b0, 4'd3, '0, c1);
        wait_rsp(d, e, c2);
        chk("raw_back_to_back", 64'(c1 - c0), 1);
        chk("raw_data", d, 32'hDEADBEEF);
        chk("raw_err", e, 0);
        chk("raw_latency", 64'(c2 - c1), 3);

        // Read then write the same address: read sees the old value.
        wait_idle();
        send(1'b1, 4'd5, 32'hA5A5A5A5, c0);
        wait_idle();
        send(1'b0, 4'd5, '0, c0);
        send(1'b1, 4'd5, 32'h1, c1);
        wait_rsp(d, e, c2);
        chk("war_old_data", d, 32'hA5A5A5A5);
        send(1'b0, 4'd5, '0, c0);
        wait_rsp(d, e, c2);
        chk("war_new_data", d, 32'h1);

        // Six reads with the response side blocked.
        wait_idle();
        rsp_ready = 1'b0;
        base_rd   = rd_issue_cnt;
        base_pop  = pop_cnt;
        for (int i = 0; i < 6; i++) send(1'b0, ADDR_W'(i), '0, c0);
        repeat (4) tick();
        chk("credit_reads_issued", 64'(rd_issue_cnt - base_rd), 2);
        chk("credit_req_ready", req_ready, 0);
        chk("credit_busy", busy, 1);
        chk("credit_head_rsp", {rsp_valid, rsp_rdata}, {1'b1, seed(0)});
        rsp_ready = 1'b1;
        wait_idle();
        chk("credit_all_popped", 64'(pop_cnt - base_pop), 6);

        // Reset with commands queued and a read in flight.
        wait_idle();
        rsp_ready = 1'b0;
        send(1'b0, 4'd1, '0, c0);
        send(1'b0, 4'd2, '0, c0);
        repeat (3) tick();
        send(1'b0, 4'd4, '0, c0);
        send(1'b0, 4'd0, '0, c0);
        send(1'b1, 4'd6, 32'h77, c0);
        send(1'b1, 4'd7, 32'h88, c0);
        repeat (3) tick();
        base_wr   = wr_issue_cnt;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        chk("pre_rst_inflight_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("rst_no_rsp", {rsp_valid, busy}, 0);
        chk("rst_no_writes", 64'(wr_issue_cnt - base_wr), 0);
        chk("rst_ram6_untouched", ram[6], seed(6));
        chk("rst_ram7_untouched", ram[7], seed(7));
        rsp_ready = 1'b1;

        // Out-of-range addresses.
        wait_idle();
        base_wr   = wr_issue_cnt;
        base_drop = drop_cnt;
        base_rd   = rd_issue_cnt;
`ifdef RAM_CTRL_ADDR_CHECK_EN
        send(1'b1, 4'd9, 32'h1234, c0);
        wait_idle();
        chk("oor_drop_pulse", 64'(drop_cnt - base_drop), 1);
        chk("oor_no_write", 64'(wr_issue_cnt - base_wr), 0);
        send(1'b0, 4'd12, '0, c1);
        wait_rsp(d, e, c2);
        chk("oor_rd_err", e, 1);
        chk("oor_rd_data", d, 0);
        chk("oor_rd_latency", 64'(c2 - c1), 3);
        chk("oor_no_read", 64'(rd_issue_cnt - base_rd), 0);
`else
        send(1'b0, 4'd12, '0, c1);
        wait_rsp(d, e, c2);
        chk("hi_rd_addr", last_rd_addr, 12);
        chk("hi_rd_data", d, seed(12));
        chk("hi_rd_err", e, 0);
        chk("hi_rd_latency", 64'(c2 - c1), 3);
`endif

        // Random traffic against the scoreboard.
        wait_idle();
        for (int i = 0; i < 800; i++) begin
            req_valid = $urandom_range(0, 99) < 70;
            req_wr    = $urandom_range(0, 1) == 1;
            req_addr  = ADDR_W'($urandom_range(0, 15));
            req_wdata = $urandom;
            rsp_ready = $urandom_range(0, 99) < 70;
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        chk("final_drain", 64'(expq.size() + wq.size() + rdq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_req_ctrl.md
RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, 32, data width
- ADDR_W, 4, address width
- MEM_DEPTH, 8, valid RAM locations
- CMD_DEPTH, 4, command FIFO entries (power of 2)
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high with req_valid
- req_wr  in  1  1=write, 0=read
- req_addr  in  ADDR_W  command address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  response address error
- wr_drop  out  1  one-cycle pulse: write dropped
- ram_wr_enb  out  1  RAM write enable
- ram_wr_addr  out  ADDR_W  RAM write address
- ram_data_in  out  DATA_W  RAM write data
- ram_rd_enb  out  1  RAM read enable
- ram_rd_addr  out  ADDR_W  RAM read address
- ram_data_out  in  DATA_W  RAM registered read data, valid cycle after ram_rd_enb
- busy  out  1  any command or response pending
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 Commands SHALL enter a CMD_DEPTH FIFO; req_ready = !full; no bypass when full, even if a pop occurs that cycle.
REQ-005 When FIFO is non-empty, the head SHALL issue combinationally to the RAM port that cycle and pop at the same edge, at most one command per cycle.
REQ-006 A write head SHALL always issue: ram_wr_enb=1, ram_wr_addr=addr, ram_data_in=wdata; no response generated.
REQ-007 A read head SHALL issue only if in-flight reads plus buffered responses < 2; otherwise it SHALL stall, blocking subsequent writes.
REQ-008 Read issued in cycle N SHALL capture ram_data_out at the end of cycle N+1 into a 2-entry response FIFO; an accept in cycle T into an empty system gives rsp_valid in cycle T+3.
REQ-009 Responses SHALL return in issue order; rsp_valid/rsp_rdata/rsp_err SHALL hold stable until rsp_ready.
REQ-010 Read after write to the same address, issued in consecutive cycles, SHALL return the new data; write after read SHALL return old data.
REQ-011 Inactive RAM enable ports SHALL drive address and data as 0.
REQ-012 busy = FIFO non-empty OR read in flight OR response FIFO non-empty.
REQ-013 Simultaneous response push and pop SHALL keep the count unchanged with no data loss.

Reset
REQ-014 On rst at posedge: flush both FIFOs; drop any in-flight read; req_ready=0 during reset, 1 the cycle after.
REQ-015 Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_drop=0, busy=0, all ram_* outputs=0.
REQ-016 Reset mid-operation SHALL discard pending commands without issuing them; RAM contents SHALL be untouched.

Configuration
REQ-017 Macro RAM_CTRL_ADDR_CHECK_EN defined:
- addr >= MEM_DEPTH: write not issued; wr_drop pulses for the pop cycle.
- Read not issued to RAM; it still takes a credit and returns in order with the normal latency, rsp_err=1, rsp_rdata=0.
REQ-018 Macro undefined: addresses pass unchanged; rsp_err and wr_drop tied to 0.

Verification
REQ-019 Write addr 3 data 0xDEADBEEF, then read addr 3 next cycle -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after read accept.
REQ-020 Hold rsp_ready=0 and push 6 reads -> exactly 2 reads issued, FIFO fills to 4, req_ready=0; release -> all 6 responses in order.
REQ-021 Read addr 5 then write addr 5 = 0x1 back-to-back, prior value 0xA5A5A5A5 -> response 0xA5A5A5A5.
REQ-022 Assert rst with 3 commands queued and 1 read in flight -> no further ram enables, rsp_valid=0, busy=0 next cycle.
REQ-023 With RAM_CTRL_ADDR_CHECK_EN: write addr 9 -> wr_drop pulse, no ram_wr_enb; read addr 12 -> rsp_err=1, rsp_rdata=0; without macro: read addr 12 issued with ram_rd_addr=12.
